// File: rtl/arb_pkg.sv
// Shared types for the instruction/data sram-like bus arbiter:
// owner IDs, access size codes and the muxed request bundle.
package arb_pkg;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2
    } size_e;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } sram_req_t;

endpackage

// File: rtl/owner_fifo.sv
// In-order record of which master owns each accepted-but-unanswered
// transaction; head is the owner of the next response from memory.
module owner_fifo
    import arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   push,
    input  owner_e push_owner,
    input  logic   pop,
    output logic   full,
    output logic   empty,
    output owner_e head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    owner_e           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
        else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking so every flop samples the pre-edge values, independent of statement order.
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; count_q alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_owner;
    end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one sram-like memory port between the instruction and data masters:
// priority grant with anti-starvation, request lock, in-order response routing.
module sram_bus_arbiter
    import arb_pkg::*;
#(
    parameter int OUTSTANDING = 2,
    parameter int STARVE_MAX  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,
    output logic        proto_err
);

    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    sram_req_t           inst_bus, data_bus, mem_bus;
    owner_e              grant, head_owner;
    owner_e              lock_id_q, lock_id_d;
    logic                lock_q, lock_d;
    logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
    logic                proto_err_q, proto_err_d;
    logic                grant_req, accept, resp_valid;
    logic                fifo_full, fifo_empty;

    assign inst_bus = '{wr: inst_wr, size: inst_size, wstrb: inst_wstrb,
                        addr: inst_addr, wdata: inst_wdata};
    assign data_bus = '{wr: data_wr, size: data_size, wstrb: data_wstrb,
                        addr: data_addr, wdata: data_wdata};

    // A locked grant keeps the presented request stable until the slave takes it.
    always_comb begin
        grant = OWN_DATA;
        if (lock_q)
            grant = lock_id_q;
        else if (inst_req && (starve_cnt_q == STARVE_W'(STARVE_MAX) || !data_req))
            grant = OWN_INST;
    end

    assign grant_req = (grant == OWN_DATA) ? data_req : inst_req;
    assign mem_bus   = (grant == OWN_DATA) ? data_bus : inst_bus;

    // fifo_full is registered state, so mem_data_ok never reaches mem_req.
    assign mem_req   = grant_req & ~fifo_full;
    assign mem_wr    = mem_bus.wr;
    assign mem_size  = mem_bus.size;
    assign mem_wstrb = mem_bus.wstrb;
    assign mem_addr  = mem_bus.addr;
    assign mem_wdata = mem_bus.wdata;

    assign accept       = mem_req & mem_addr_ok;
    assign inst_addr_ok = accept & (grant == OWN_INST);
    assign data_addr_ok = accept & (grant == OWN_DATA);

    assign resp_valid   = mem_data_ok & ~fifo_empty;
    assign inst_data_ok = resp_valid & (head_owner == OWN_INST);
    assign data_data_ok = resp_valid & (head_owner == OWN_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;
    assign proto_err    = proto_err_q;

    always_comb begin
        lock_d       = mem_req & ~mem_addr_ok;
        lock_id_d    = grant;
        proto_err_d  = proto_err_q | (mem_data_ok & fifo_empty);
        starve_cnt_d = starve_cnt_q;
        if (!inst_req || (accept && grant == OWN_INST))
            starve_cnt_d = '0;
        else if (accept && starve_cnt_q != STARVE_W'(STARVE_MAX))
            starve_cnt_d = starve_cnt_q + STARVE_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_q       <= 1'b0;
            lock_id_q    <= OWN_DATA;
            starve_cnt_q <= '0;
            proto_err_q  <= 1'b0;
        end else begin
            lock_q       <= lock_d;
            lock_id_q    <= lock_id_d;
            starve_cnt_q <= starve_cnt_d;
            proto_err_q  <= proto_err_d;
        end
    end

    owner_fifo #(
        .DEPTH(OUTSTANDING)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (accept),
        .push_owner(grant),
        .pop       (mem_data_ok),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head_owner)
    );

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Self-checking bench for sram_bus_arbiter: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_sram_bus_arbiter;
    import arb_pkg::*;

    localparam int OUTSTANDING = 2;
    localparam int STARVE_MAX  = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [3:0]  inst_wstrb;
    logic [31:0] inst_addr, inst_wdata;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;
    logic        proto_err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sram_bus_arbiter #(
        .OUTSTANDING(OUTSTANDING),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
        .proto_err(proto_err)
    );

    task automatic idle_inputs();
        inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_wstrb = 4'h0;
        inst_addr = 32'h0; inst_wdata = 32'h0;
        data_req = 0; data_wr = 0; data_size = 2'd2; data_wstrb = 4'h0;
        data_addr = 32'h0; data_wdata = 32'h0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 32'h0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, proto_err} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want 000000",
                     {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, proto_err});
        end
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({mem_req, proto_err} !== 2'b00) begin
            n_err++;
            $display("FAIL after_reset_idle: got %b want 00", {mem_req, proto_err});
        end
        next_cycle();
    endtask

    task automatic test_single_read();
        do_reset();
        inst_req = 1; inst_addr = 32'h1c000000; inst_size = 2'd2; mem_addr_ok = 1;
        @(negedge clk);
        n_cmp++;
        if ({mem_req, inst_addr_ok, data_addr_ok} !== 3'b110 || mem_addr !== 32'h1c000000) begin
            n_err++;
            $display("FAIL single_read_issue: req/iok/dok=%b addr=%h want 110 1c000000",
                     {mem_req, inst_addr_ok, data_addr_ok}, mem_addr);
        end
        next_cycle();
        inst_req = 0; mem_addr_ok = 0;
        next_cycle();
        mem_data_ok = 1; mem_rdata = 32'h02800c0c;
        @(negedge clk);
        n_cmp++;
        if ({inst_data_ok, data_data_ok} !== 2'b10 || inst_rdata !== 32'h02800c0c) begin
            n_err++;
            $display("FAIL single_read_resp: iok/dok=%b rdata=%h want 10 02800c0c",
                     {inst_data_ok, data_data_ok}, inst_rdata);
        end
        next_cycle();
        mem_data_ok = 0;
        @(negedge clk);
        n_cmp++;
        if (proto_err !== 1'b0) begin
            n_err++;
            $display("FAIL single_read_proto: got %b want 0", proto_err);
        end
        next_cycle();
    endtask

    task automatic test_collision_lock();
        do_reset();
        inst_req = 1; inst_addr = 32'h1c000100;
        data_req = 1; data_addr = 32'h80001000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({mem_req, inst_addr_ok, data_addr_ok} !== 3'b100 || mem_addr !== 32'h80001000) begin
                n_err++;
                $display("FAIL collision_wait%0d: req/iok/dok=%b addr=%h want 100 80001000",
                         i, {mem_req, inst_addr_ok, data_addr_ok}, mem_addr);
            end
            next_cycle();
        end
        mem_addr_ok = 1;
        @(negedge clk);
        n_cmp++;
        if ({mem_req, inst_addr_ok, data_addr_ok} !== 3'b101 || mem_addr !== 32'h80001000) begin
            n_err++;
            $display("FAIL collision_data_accept: req/iok/dok=%b addr=%h want 101 80001000",
                     {mem_req, inst_addr_ok, data_addr_ok}, mem_addr);
        end
        next_cycle();
        data_req = 0;
        @(negedge clk);
        n_cmp++;
        if ({mem_req, inst_addr_ok, data_addr_ok} !== 3'b110 || mem_addr !== 32'h1c000100) begin
            n_err++;
            $display("FAIL collision_inst_next: req/iok/dok=%b addr=%h want 110 1c000100",
                     {mem_req, inst_addr_ok, data_addr_ok}, mem_addr);
        end
        next_cycle();

        // inst locked first: a later data request must not steal the grant
        do_reset();
        inst_req = 1; inst_addr = 32'h1c000200;
        next_cycle();
        data_req = 1; data_addr = 32'h80002000;
        @(negedge clk);
        n_cmp++;
        if ({mem_req, inst_addr_ok, data_addr_ok} !== 3'b100 || mem_addr !== 32'h1c000200) begin
            n_err++;
            $display("FAIL lock_inst_hold: req/iok/dok=%b addr=%h want 100 1c000200",
                     {mem_req, inst_addr_ok, data_addr_ok}, mem_addr);
        end
        next_cycle();
        mem_addr_ok = 1;
        @(negedge clk);
        n_cmp++;
        if ({mem_req, inst_addr_ok, data_addr_ok} !== 3'b110) begin
            n_err++;
            $display("FAIL lock_inst_accept: req/iok/dok=%b want 110",
                     {mem_req, inst_addr_ok, data_addr_ok});
        end
        next_cycle();
        inst_req = 0;
        @(negedge clk);
        n_cmp++;
        if ({mem_req, inst_addr_ok, data_addr_ok} !== 3'b101 || mem_addr !== 32'h80002000) begin
            n_err++;
            $display("FAIL lock_release_data: req/iok/dok=%b addr=%h want 101 80002000",
                     {mem_req, inst_addr_ok, data_addr_ok}, mem_addr);
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_full_fifo();
        do_reset();
        data_req = 1; mem_addr_ok = 1;
        for (int i = 0; i < 2; i++) begin
            data_addr = 32'h100 + 32'(4 * i);
            @(negedge clk);
            n_cmp++;
            if ({mem_req, data_addr_ok} !== 2'b11) begin
                n_err++;
                $display("FAIL full_accept%0d: req/dok=%b want 11", i, {mem_req, data_addr_ok});
            end
            next_cycle();
        end
        data_addr = 32'h108;
        @(negedge clk);
        n_cmp++;
        if ({mem_req, data_addr_ok} !== 2'b00) begin
            n_err++;
            $display("FAIL full_blocked: req/dok=%b want 00", {mem_req, data_addr_ok});
        end
        next_cycle();
        mem_data_ok = 1;
        @(negedge clk);
        n_cmp++;
        if ({mem_req, data_addr_ok, data_data_ok} !== 3'b001) begin
            n_err++;
            $display("FAIL full_pop_same_cycle: req/aok/dok=%b want 001",
                     {mem_req, data_addr_ok, data_data_ok});
        end
        next_cycle();
        mem_data_ok = 0;
        @(negedge clk);
        n_cmp++;
        if ({mem_req, data_addr_ok} !== 2'b11 || mem_addr !== 32'h108) begin
            n_err++;
            $display("FAIL full_after_pop: req/dok=%b addr=%h want 11 00000108",
                     {mem_req, data_addr_ok}, mem_addr);
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_ordering();
        do_reset();
        mem_addr_ok = 1;
        inst_req = 1; inst_addr = 32'h1c000300;
        @(negedge clk);
        n_cmp++;
        if (inst_addr_ok !== 1'b1) begin
            n_err++;
            $display("FAIL order_inst_accept: got %b want 1", inst_addr_ok);
        end
        next_cycle();
        inst_req = 0;
        data_req = 1; data_wr = 1; data_wstrb = 4'hf; data_addr = 32'h80003000; data_wdata = 32'hcafef00d;
        @(negedge clk);
        n_cmp++;
        if ({mem_req, data_addr_ok, mem_wr} !== 3'b111 || mem_wdata !== 32'hcafef00d) begin
            n_err++;
            $display("FAIL order_write_accept: req/dok/wr=%b wdata=%h want 111 cafef00d",
                     {mem_req, data_addr_ok, mem_wr}, mem_wdata);
        end
        next_cycle();
        data_wr = 0; data_wstrb = 4'h0; data_addr = 32'h80003004;
        mem_data_ok = 1; mem_rdata = 32'h11111111;
        @(negedge clk);
        n_cmp++;
        if ({mem_req, inst_data_ok, data_data_ok} !== 3'b010 || inst_rdata !== 32'h11111111) begin
            n_err++;
            $display("FAIL order_resp0_inst: req/iok/dok=%b rdata=%h want 010 11111111",
                     {mem_req, inst_data_ok, data_data_ok}, inst_rdata);
        end
        next_cycle();
        mem_rdata = 32'h22222222;
        @(negedge clk);
        n_cmp++;
        if ({mem_req, data_addr_ok, inst_data_ok, data_data_ok} !== 4'b1101) begin
            n_err++;
            $display("FAIL order_resp1_write: req/aok/iok/dok=%b want 1101",
                     {mem_req, data_addr_ok, inst_data_ok, data_data_ok});
        end
        next_cycle();
        data_req = 0; mem_rdata = 32'h33333333;
        @(negedge clk);
        n_cmp++;
        if ({inst_data_ok, data_data_ok} !== 2'b01 || data_rdata !== 32'h33333333) begin
            n_err++;
            $display("FAIL order_resp2_data: iok/dok=%b rdata=%h want 01 33333333",
                     {inst_data_ok, data_data_ok}, data_rdata);
        end
        next_cycle();
        mem_data_ok = 0;
        @(negedge clk);
        n_cmp++;
        if (proto_err !== 1'b0) begin
            n_err++;
            $display("FAIL order_proto: got %b want 0", proto_err);
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_starvation();
        logic exp_i, prev_i;
        do_reset();
        inst_req = 1; inst_addr = 32'h1c000400;
        data_req = 1; data_addr = 32'h80004000;
        mem_addr_ok = 1;
        prev_i = 1'b0;
        for (int k = 0; k < 15; k++) begin
            exp_i = ((k % 5) == 4);
            mem_data_ok = (k > 0);
            @(negedge clk);
            n_cmp++;
            if ({inst_addr_ok, data_addr_ok} !== {exp_i, ~exp_i}) begin
                n_err++;
                $display("FAIL starve_grant%0d: iok/dok=%b want %b",
                         k, {inst_addr_ok, data_addr_ok}, {exp_i, ~exp_i});
            end
            if (k > 0) begin
                n_cmp++;
                if ({inst_data_ok, data_data_ok} !== {prev_i, ~prev_i}) begin
                    n_err++;
                    $display("FAIL starve_route%0d: iok/dok=%b want %b",
                             k, {inst_data_ok, data_data_ok}, {prev_i, ~prev_i});
                end
            end
            prev_i = exp_i;
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_error_reset();
        do_reset();
        mem_data_ok = 1;
        @(negedge clk);
        n_cmp++;
        if ({inst_data_ok, data_data_ok, proto_err} !== 3'b000) begin
            n_err++;
            $display("FAIL err_empty_resp: iok/dok/perr=%b want 000",
                     {inst_data_ok, data_data_ok, proto_err});
        end
        next_cycle();
        mem_data_ok = 0;
        inst_req = 1; inst_addr = 32'h1c000500; mem_addr_ok = 1;
        @(negedge clk);
        n_cmp++;
        if ({proto_err, inst_addr_ok} !== 2'b11) begin
            n_err++;
            $display("FAIL err_sticky: perr/iok=%b want 11", {proto_err, inst_addr_ok});
        end
        next_cycle();
        inst_req = 0; data_req = 1; data_addr = 32'h80005000; mem_addr_ok = 0;
        @(negedge clk);
        n_cmp++;
        if ({mem_req, data_addr_ok, proto_err} !== 3'b101) begin
            n_err++;
            $display("FAIL err_lock_setup: req/dok/perr=%b want 101",
                     {mem_req, data_addr_ok, proto_err});
        end
        next_cycle();
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({proto_err, dut.lock_q} !== 2'b00 || dut.u_fifo.count_q !== '0) begin
            n_err++;
            $display("FAIL err_async_reset: perr/lock=%b count=%0d want 00 0",
                     {proto_err, dut.lock_q}, dut.u_fifo.count_q);
        end
        @(negedge clk);
        reset = 1'b0;
        data_req = 0; mem_data_ok = 1;
        #1;
        n_cmp++;
        if ({inst_data_ok, data_data_ok} !== 2'b00) begin
            n_err++;
            $display("FAIL err_late_resp: iok/dok=%b want 00", {inst_data_ok, data_data_ok});
        end
        next_cycle();
        mem_data_ok = 0;
        @(negedge clk);
        n_cmp++;
        if (proto_err !== 1'b1) begin
            n_err++;
            $display("FAIL err_late_proto: got %b want 1", proto_err);
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_random();
        owner_e      q[$];
        int          m_starve;
        logic        m_locked;
        owner_e      m_lock_owner;
        owner_e      g, head;
        logic        g_req, e_mem_req, e_acc, e_resp;
        logic [70:0] exp_f;
        do_reset();
        m_starve = 0;
        m_locked = 1'b0;
        m_lock_owner = OWN_DATA;
        for (int c = 0; c < 600; c++) begin
            if (!inst_req && $urandom_range(0, 1) == 1) begin
                inst_req = 1; inst_wr = 1'($urandom_range(0, 1));
                inst_size = 2'($urandom_range(0, 2)); inst_wstrb = 4'($urandom);
                inst_addr = $urandom; inst_wdata = $urandom;
            end
            if (!data_req && $urandom_range(0, 1) == 1) begin
                data_req = 1; data_wr = 1'($urandom_range(0, 1));
                data_size = 2'($urandom_range(0, 2)); data_wstrb = 4'($urandom);
                data_addr = $urandom; data_wdata = $urandom;
            end
            mem_addr_ok = ($urandom_range(0, 9) < 6);
            mem_data_ok = (q.size() > 0) && ($urandom_range(0, 1) == 1);
            mem_rdata   = $urandom;

            if (m_locked) g = m_lock_owner;
            else if (inst_req && (m_starve == STARVE_MAX || !data_req)) g = OWN_INST;
            else g = OWN_DATA;
            g_req     = (g == OWN_INST) ? inst_req : data_req;
            e_mem_req = g_req && (q.size() < OUTSTANDING);
            e_acc     = e_mem_req && mem_addr_ok;
            e_resp    = mem_data_ok && (q.size() > 0);
            head      = (q.size() > 0) ? q[0] : OWN_INST;
            exp_f     = (g == OWN_INST) ? {inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata}
                                        : {data_wr, data_size, data_wstrb, data_addr, data_wdata};

            @(negedge clk);
            n_cmp++;
            if ({mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, proto_err} !==
                {e_mem_req, e_acc && g == OWN_INST, e_acc && g == OWN_DATA,
                 e_resp && head == OWN_INST, e_resp && head == OWN_DATA, 1'b0}) begin
                n_err++;
                $display("FAIL rand_ctrl c=%0d: req/iaok/daok/idok/ddok/perr=%b want %b", c,
                         {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, proto_err},
                         {e_mem_req, e_acc && g == OWN_INST, e_acc && g == OWN_DATA,
                          e_resp && head == OWN_INST, e_resp && head == OWN_DATA, 1'b0});
            end
            if (e_mem_req) begin
                n_cmp++;
                if ({mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata} !== exp_f) begin
                    n_err++;
                    $display("FAIL rand_mux c=%0d: got %h want %h", c,
                             {mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata}, exp_f);
                end
            end
            n_cmp++;
            if (inst_rdata !== mem_rdata || data_rdata !== mem_rdata) begin
                n_err++;
                $display("FAIL rand_rdata c=%0d: inst=%h data=%h want %h",
                         c, inst_rdata, data_rdata, mem_rdata);
            end

            if (e_resp) void'(q.pop_front());
            if (e_acc) q.push_back(g);
            m_locked     = e_mem_req && !mem_addr_ok;
            m_lock_owner = g;
            if (!inst_req || (e_acc && g == OWN_INST)) m_starve = 0;
            else if (e_acc && m_starve < STARVE_MAX) m_starve++;

            next_cycle();
            if (e_acc && g == OWN_INST) inst_req = 0;
            if (e_acc && g == OWN_DATA) data_req = 0;
        end
        idle_inputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_read();
        test_collision_lock();
        test_full_fifo();
        test_ordering();
        test_starvation();
        test_error_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
